// File: rtl/zio_strobe.sv
// Z80 I/O strobe generator: porthit decode, control-line synchronisers and one-fclk rd/wr strobes.
// Build option: define ZIO_INTACK_EN to emit int_ack pulses and latch the address on INTA cycles.
module zio_strobe #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [15:0] HIT0_MASK   = 16'h0001,
  parameter logic [15:0] HIT0_VAL    = 16'h0000,
  parameter logic [15:0] HIT1_MASK   = 16'hC002,
  parameter logic [15:0] HIT1_VAL    = 16'h4000
) (
  input  logic        fclk,
  input  logic        rst,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic        m1_n,
  input  logic [15:0] a,
  input  logic [7:0]  d,
  output logic        porthit,
  output logic        port_rd,
  output logic        port_wr,
  output logic        port_hit_q,
  output logic [15:0] port_addr,
  output logic [7:0]  port_wdata,
  output logic        busy,
  output logic        int_ack
);

  localparam int unsigned LastStage = SYNC_STAGES - 1;
  localparam logic [2:0]  ArmCycles = 3'(SYNC_STAGES);

  typedef enum logic [2:0] {StArm, StIdle, StRd, StWr, StAck} state_e;

  state_e      state_q, state_d;
  logic [2:0]  arm_cnt_q, arm_cnt_d;
  logic [3:0]  sync_q [SYNC_STAGES];
  logic        s_iorq, s_rd, s_wr, s_m1;
  logic        enter_rd, enter_wr;
  logic        port_rd_q, port_wr_q, hit_q;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q;

  assign porthit = m1_n & (((a & HIT0_MASK) == HIT0_VAL) | ((a & HIT1_MASK) == HIT1_VAL));

  // Bit order in each stage: {m1_n, wr_n, rd_n, iorq_n}; reset to all-inactive.
  always_ff @(posedge fclk) begin
    if (rst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 4'hF;
    end else begin
      sync_q[0] <= {m1_n, wr_n, rd_n, iorq_n};
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign s_iorq = sync_q[LastStage][0];
  assign s_rd   = sync_q[LastStage][1];
  assign s_wr   = sync_q[LastStage][2];
  assign s_m1   = sync_q[LastStage][3];

  always_ff @(posedge fclk) begin
    if (rst) begin
      state_q   <= StArm;
      arm_cnt_q <= 3'd0;
    end else begin
      state_q   <= state_d;
      arm_cnt_q <= arm_cnt_d;
    end
  end

  // ARM first lets the reset-filled chain refill with real pin levels, so a cycle
  // already in progress at reset release is seen as such and skipped.
  always_comb begin
    state_d   = state_q;
    arm_cnt_d = arm_cnt_q;
    unique case (state_q)
      StArm: begin
        if (arm_cnt_q != ArmCycles) begin
          arm_cnt_d = arm_cnt_q + 3'd1;
        end else if (s_iorq) begin
          state_d = StIdle;
        end
      end
      StIdle: begin
        if (!s_iorq) begin
          if (s_m1 && !s_rd) begin
            state_d = StRd;
          end else if (s_m1 && !s_wr) begin
            state_d = StWr;
          end else if (!s_m1) begin
            state_d = StAck;
          end
        end
      end
      StRd, StWr, StAck: begin
        if (s_iorq) state_d = StIdle;
      end
      default: state_d = StArm;
    endcase
  end

  always_comb begin
    enter_rd = (state_q == StIdle) && (state_d == StRd);
    enter_wr = (state_q == StIdle) && (state_d == StWr);
    busy     = (state_q == StRd) || (state_q == StWr) || (state_q == StAck);
  end

  always_ff @(posedge fclk) begin
    if (rst) begin
      port_rd_q <= 1'b0;
      port_wr_q <= 1'b0;
      hit_q     <= 1'b0;
      addr_q    <= 16'h0000;
      wdata_q   <= 8'h00;
    end else begin
      port_rd_q <= enter_rd;
      port_wr_q <= enter_wr;
      if (enter_rd || enter_wr) begin
        addr_q <= a;
        hit_q  <= porthit;
      end
      if (enter_wr) wdata_q <= d;
`ifdef ZIO_INTACK_EN
      if ((state_q == StIdle) && (state_d == StAck)) addr_q <= a;
`endif
    end
  end

`ifdef ZIO_INTACK_EN
  logic int_ack_q;

  always_ff @(posedge fclk) begin
    if (rst) begin
      int_ack_q <= 1'b0;
    end else begin
      int_ack_q <= (state_q == StIdle) && (state_d == StAck);
    end
  end

  assign int_ack = int_ack_q;
`else
  assign int_ack = 1'b0;
`endif

  assign port_rd    = port_rd_q;
  assign port_wr    = port_wr_q;
  assign port_hit_q = hit_q;
  assign port_addr  = addr_q;
  assign port_wdata = wdata_q;

endmodule
